// File: rtl/inventory_bank_fsm.sv
// ----------------------------------------------------------------------------
// inventory_bank_fsm
//   Multi-channel stock tracker for the vending datapath. Each product channel
//   holds a saturating unit counter. Dispense requests go through a
//   req/ack/nack handshake FSM. Channels can be restocked one unit at a time
//   or all reloaded to CAPACITY at once. Per-channel status flags are decoded
//   from the registered counts.
//
// Ports
//   clk1         in   system clock, rising edge
//   reset1       in   asynchronous, active-high reset
//   disp_req     in   dispense request, held high until ack/nack is seen
//   disp_sel     in   requested channel, sampled in IDLE together with disp_req
//   disp_ack     out  1-cycle pulse: one unit dispensed
//   disp_nack    out  1-cycle pulse: request refused (empty or invalid channel)
//   busy         out  handshake in progress (FSM not in IDLE)
//   restock_inc  in   per-channel +1 strobe, saturates at CAPACITY
//   restock_all  in   reload every channel with CAPACITY
//   stock_count  out  packed counts, channel i at [i*CNT_W +: CNT_W]
//   not_empty    out  per-channel: stock remains
//   low_stock    out  per-channel: 0 < count <= LOW_THRESH
//   all_empty    out  every channel at 0
// ----------------------------------------------------------------------------
module inventory_bank_fsm #(
  parameter  int NUM_ITEMS  = 4,
  parameter  int CAPACITY   = 3,
  parameter  int LOW_THRESH = 1,
  localparam int CNT_W      = $clog2(CAPACITY + 1),
  localparam int SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                       clk1,
  input  logic                       reset1,
  input  logic                       disp_req,
  input  logic [SEL_W-1:0]           disp_sel,
  output logic                       disp_ack,
  output logic                       disp_nack,
  output logic                       busy,
  input  logic [NUM_ITEMS-1:0]       restock_inc,
  input  logic                       restock_all,
  output logic [NUM_ITEMS*CNT_W-1:0] stock_count,
  output logic [NUM_ITEMS-1:0]       not_empty,
  output logic [NUM_ITEMS-1:0]       low_stock,
  output logic                       all_empty
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DENY,
    WAIT_REL
  } state_e;

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] LOW_C = CNT_W'(LOW_THRESH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q [NUM_ITEMS];
  logic [CNT_W-1:0]     cnt_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] hit;   // selected channel has stock
  logic [NUM_ITEMS-1:0] dec;   // channel decremented by a grant this edge

  // Handshake FSM: next state and grant decode.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    dec     = '0;
    hit     = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      // An out-of-range select matches no channel, so it falls through to DENY.
      hit[i] = (int'(disp_sel) == i) && (cnt_q[i] != '0);
    end
    unique case (state_q)
      IDLE: begin
        // restock_all holds the request in IDLE; it is re-evaluated next cycle
        // against the reloaded counts.
        if (disp_req && !restock_all) begin
          if (|hit) begin
            state_d = GRANT;
            dec     = hit;
          end else begin
            state_d = DENY;
          end
        end
      end
      GRANT:    state_d = WAIT_REL;
      DENY:     state_d = WAIT_REL;
      WAIT_REL: if (!disp_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Per-channel counter update: reload > (dec with inc) > dec > inc.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (restock_all) begin
        cnt_d[i] = CAP_C;
      end else if (dec[i] && restock_inc[i]) begin
        cnt_d[i] = cnt_q[i];
      end else if (dec[i]) begin
        cnt_d[i] = cnt_q[i] - ONE_C;
      end else if (restock_inc[i] && (cnt_q[i] < CAP_C)) begin
        cnt_d[i] = cnt_q[i] + ONE_C;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      state_q <= IDLE;
      // NOTE: the count array is real state whose reset value is visible on
      // the outputs (full stock), so every entry is reset, not left as a RAM.
      for (int i = 0; i < NUM_ITEMS; i++) begin
        cnt_q[i] <= CAP_C;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Moore handshake outputs.
  assign disp_ack  = (state_q == GRANT);
  assign disp_nack = (state_q == DENY);
  assign busy      = (state_q != IDLE);

  // Status flags decoded from the registered counts.
  always_comb begin
    stock_count = '0;
    not_empty   = '0;
    low_stock   = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      stock_count[i*CNT_W +: CNT_W] = cnt_q[i];
      not_empty[i]                  = (cnt_q[i] != '0);
      low_stock[i]                  = (cnt_q[i] != '0) && (cnt_q[i] <= LOW_C);
    end
  end

  assign all_empty = ~|not_empty;

endmodule

// File: tb/tb_inventory_bank_fsm.sv
// ----------------------------------------------------------------------------
// tb_inventory_bank_fsm
//   Directed bench for inventory_bank_fsm with default parameters
//   (4 channels, capacity 3, low threshold 1). A per-cycle vector table
//   covers the basic dispense/deny/restock-inc flow on channel 2; hand-written
//   sequences cover held requests, draining, restock_all interplay and
//   asynchronous reset in the middle of a handshake.
// ----------------------------------------------------------------------------
module tb_inventory_bank_fsm;

  logic       clk1 = 1'b0;
  logic       reset1;
  logic       disp_req;
  logic [1:0] disp_sel;
  logic       disp_ack;
  logic       disp_nack;
  logic       busy;
  logic [3:0] restock_inc;
  logic       restock_all;
  logic [7:0] stock_count;
  logic [3:0] not_empty;
  logic [3:0] low_stock;
  logic       all_empty;

  int total = 0;
  int bad   = 0;

  inventory_bank_fsm dut (
    .clk1        (clk1),
    .reset1      (reset1),
    .disp_req    (disp_req),
    .disp_sel    (disp_sel),
    .disp_ack    (disp_ack),
    .disp_nack   (disp_nack),
    .busy        (busy),
    .restock_inc (restock_inc),
    .restock_all (restock_all),
    .stock_count (stock_count),
    .not_empty   (not_empty),
    .low_stock   (low_stock),
    .all_empty   (all_empty)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic       req;
    logic [1:0] sel;
    logic [3:0] inc;
    logic       all;
    logic       ack;
    logic       nack;
    logic       busy;
    logic [7:0] cnt;
    logic [3:0] ne;
    logic [3:0] low;
    logic       ae;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic req, logic [1:0] sel, logic [3:0] inc,
                              logic all, logic ack, logic nack, logic bsy,
                              logic [7:0] cnt, logic [3:0] ne, logic [3:0] low,
                              logic ae);
    vec_t v;
    v.req = req; v.sel = sel; v.inc = inc; v.all = all;
    v.ack = ack; v.nack = nack; v.busy = bsy;
    v.cnt = cnt; v.ne = ne; v.low = low; v.ae = ae;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic check_idle_state(input string tag, input logic [7:0] cnt,
                                  input logic [3:0] ne, input logic ae);
    check({tag, " busy"},  32'(busy), 32'd0);
    check({tag, " ack"},   32'(disp_ack), 32'd0);
    check({tag, " nack"},  32'(disp_nack), 32'd0);
    check({tag, " count"}, 32'(stock_count), 32'(cnt));
    check({tag, " ne"},    32'(not_empty), 32'(ne));
    check({tag, " ae"},    32'(all_empty), 32'(ae));
  endtask

  // Full handshake: request, check ack/nack, release, return to IDLE.
  task automatic dispense(input logic [1:0] sel, input logic exp_ack,
                          input string tag);
    disp_req = 1'b1;
    disp_sel = sel;
    step();
    check({tag, " ack"},  32'(disp_ack), 32'(exp_ack));
    check({tag, " nack"}, 32'(disp_nack), 32'(!exp_ack));
    disp_req = 1'b0;
    step();
    step();
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acks;

    // Channel order in hex count: ch3 ch2 ch1 ch0, two bits each.
    vecs[0]  = mk(1, 2, 4'h0, 0, 1, 0, 1, 8'hEF, 4'hF, 4'h0, 0); // grant, ch2 3->2
    vecs[1]  = mk(1, 2, 4'h0, 0, 0, 0, 1, 8'hEF, 4'hF, 4'h0, 0); // wait_rel
    vecs[2]  = mk(0, 2, 4'h0, 0, 0, 0, 0, 8'hEF, 4'hF, 4'h0, 0); // idle
    vecs[3]  = mk(1, 2, 4'h0, 0, 1, 0, 1, 8'hDF, 4'hF, 4'h4, 0); // ch2 2->1, low
    vecs[4]  = mk(0, 2, 4'h0, 0, 0, 0, 1, 8'hDF, 4'hF, 4'h4, 0);
    vecs[5]  = mk(0, 2, 4'h0, 0, 0, 0, 0, 8'hDF, 4'hF, 4'h4, 0);
    vecs[6]  = mk(1, 2, 4'h0, 0, 1, 0, 1, 8'hCF, 4'hB, 4'h0, 0); // ch2 1->0
    vecs[7]  = mk(0, 2, 4'h0, 0, 0, 0, 1, 8'hCF, 4'hB, 4'h0, 0);
    vecs[8]  = mk(0, 2, 4'h0, 0, 0, 0, 0, 8'hCF, 4'hB, 4'h0, 0);
    vecs[9]  = mk(1, 2, 4'h0, 0, 0, 1, 1, 8'hCF, 4'hB, 4'h0, 0); // empty: nack
    vecs[10] = mk(0, 2, 4'h0, 0, 0, 0, 1, 8'hCF, 4'hB, 4'h0, 0);
    vecs[11] = mk(0, 2, 4'h0, 0, 0, 0, 0, 8'hCF, 4'hB, 4'h0, 0);
    vecs[12] = mk(1, 2, 4'h4, 0, 0, 1, 1, 8'hDF, 4'hF, 4'h4, 0); // empty+inc: nack, ->1
    vecs[13] = mk(0, 2, 4'h0, 0, 0, 0, 1, 8'hDF, 4'hF, 4'h4, 0);
    vecs[14] = mk(0, 2, 4'h0, 0, 0, 0, 0, 8'hDF, 4'hF, 4'h4, 0);
    vecs[15] = mk(1, 2, 4'h4, 0, 1, 0, 1, 8'hDF, 4'hF, 4'h4, 0); // grant+inc: stays 1
    vecs[16] = mk(0, 2, 4'h0, 0, 0, 0, 1, 8'hDF, 4'hF, 4'h4, 0);
    vecs[17] = mk(0, 2, 4'h0, 0, 0, 0, 0, 8'hDF, 4'hF, 4'h4, 0);
    vecs[18] = mk(0, 0, 4'h1, 0, 0, 0, 0, 8'hDF, 4'hF, 4'h4, 0); // inc on full ch0

    // ---- reset ----
    reset1      = 1'b1;
    disp_req    = 1'b0;
    disp_sel    = 2'd0;
    restock_inc = 4'h0;
    restock_all = 1'b0;
    step();
    step();
    check_idle_state("reset", 8'hFF, 4'hF, 1'b0);
    check("reset low", 32'(low_stock), 32'd0);
    reset1 = 1'b0;
    step();
    check_idle_state("post-reset", 8'hFF, 4'hF, 1'b0);

    // ---- table-driven per-cycle vectors ----
    for (int i = 0; i < NV; i++) begin
      disp_req    = vecs[i].req;
      disp_sel    = vecs[i].sel;
      restock_inc = vecs[i].inc;
      restock_all = vecs[i].all;
      step();
      check($sformatf("v%0d ack", i),   32'(disp_ack),    32'(vecs[i].ack));
      check($sformatf("v%0d nack", i),  32'(disp_nack),   32'(vecs[i].nack));
      check($sformatf("v%0d busy", i),  32'(busy),        32'(vecs[i].busy));
      check($sformatf("v%0d count", i), 32'(stock_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d ne", i),    32'(not_empty),   32'(vecs[i].ne));
      check($sformatf("v%0d low", i),   32'(low_stock),   32'(vecs[i].low));
      check($sformatf("v%0d ae", i),    32'(all_empty),   32'(vecs[i].ae));
    end
    restock_inc = 4'h0;

    // ---- reload, then request held high for 10 cycles after ack ----
    restock_all = 1'b1;
    step();
    restock_all = 1'b0;
    check("reload count", 32'(stock_count), 32'hFF);
    disp_req = 1'b1;
    disp_sel = 2'd0;
    step();
    check("hold ack", 32'(disp_ack), 32'd1);
    check("hold count", 32'(stock_count), 32'hFE);
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      restock_all = (k == 4);   // reload during WAIT_REL must not disturb the handshake
      step();
      if (disp_ack) acks++;
      check($sformatf("hold busy %0d", k), 32'(busy), 32'd1);
    end
    restock_all = 1'b0;
    check("hold extra acks", 32'(acks), 32'd0);
    check("hold reload count", 32'(stock_count), 32'hFF);
    disp_req = 1'b0;
    step();
    check("hold release busy", 32'(busy), 32'd0);
    step();
    check("hold no late ack", 32'(disp_ack), 32'd0);

    // ---- drain all channels ----
    for (int ch = 0; ch < 4; ch++) begin
      for (int n = 0; n < 3; n++) begin
        dispense(2'(ch), 1'b1, $sformatf("drain ch%0d #%0d", ch, n));
      end
    end
    check_idle_state("drained", 8'h00, 4'h0, 1'b1);
    check("drained low", 32'(low_stock), 32'd0);
    dispense(2'd1, 1'b0, "drained req");
    restock_all = 1'b1;
    step();
    restock_all = 1'b0;
    check_idle_state("restock_all", 8'hFF, 4'hF, 1'b0);

    // ---- async reset during GRANT ----
    disp_req = 1'b1;
    disp_sel = 2'd3;
    step();
    check("rstG ack before", 32'(disp_ack), 32'd1);
    check("rstG count before", 32'(stock_count), 32'hBF);
    #2 reset1 = 1'b1;
    #1;
    check_idle_state("rstG async", 8'hFF, 4'hF, 1'b0);
    disp_req = 1'b0;
    step();
    reset1 = 1'b0;
    step();
    check_idle_state("rstG after1", 8'hFF, 4'hF, 1'b0);
    step();
    check_idle_state("rstG after2", 8'hFF, 4'hF, 1'b0);

    // ---- async reset during WAIT_REL ----
    disp_req = 1'b1;
    disp_sel = 2'd3;
    step();
    step();
    check("rstW busy before", 32'(busy), 32'd1);
    check("rstW ack before", 32'(disp_ack), 32'd0);
    #2 reset1 = 1'b1;
    #1;
    check_idle_state("rstW async", 8'hFF, 4'hF, 1'b0);
    disp_req = 1'b0;
    step();
    reset1 = 1'b0;
    step();
    check_idle_state("rstW after", 8'hFF, 4'hF, 1'b0);

    // ---- restock_all coincident with a request in IDLE ----
    dispense(2'd1, 1'b1, "pre-coinc");
    check("pre-coinc count", 32'(stock_count), 32'hFB);
    disp_req    = 1'b1;
    disp_sel    = 2'd1;
    restock_all = 1'b1;
    step();
    restock_all = 1'b0;
    check("coinc deferred busy", 32'(busy), 32'd0);
    check("coinc deferred ack", 32'(disp_ack), 32'd0);
    check("coinc reload count", 32'(stock_count), 32'hFF);
    step();
    check("coinc ack", 32'(disp_ack), 32'd1);
    check("coinc count", 32'(stock_count), 32'hFB);
    disp_req = 1'b0;
    step();
    step();
    check("coinc idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
